// File: rtl/index_decoder.sv
// index_decoder: rebuilds request masks from framed streams of binary indices.
// Each accepted index is one-hot decoded and ORed into an accumulator; the
// final beat of a frame publishes the mask, a saturating beat count and a
// duplicate flag, which are held on the output handshake until consumed.

module index_decoder #(
    parameter int IDX_W = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [IDX_W-1:0]      in_idx,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [2**IDX_W-1:0]   out_mask,
    output logic [IDX_W:0]        out_count,
    output logic                  out_dup
);

    localparam int MASK_W = 2**IDX_W;
    localparam logic [IDX_W:0] CNT_MAX = '1;

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

    state_t              state;
    logic [MASK_W-1:0]   acc_mask;
    logic [IDX_W:0]      acc_cnt;
    logic                acc_dup;

    logic                accept;
    logic [MASK_W-1:0]   onehot;
    logic [MASK_W-1:0]   next_mask;
    logic [IDX_W:0]      next_cnt;
    logic                next_dup;

    // Handshake flags come straight from the state register, so no input
    // can reach in_ready or out_valid combinationally.
    assign in_ready  = (state == COLLECT);
    assign out_valid = (state == HOLD);
    assign accept    = in_valid & in_ready;

    // Post-update accumulator values for the beat currently offered; the
    // duplicate test looks at the mask before this beat is merged in.
    always_comb begin
        onehot    = {{(MASK_W-1){1'b0}}, 1'b1} << in_idx;
        next_mask = acc_mask | onehot;
        next_dup  = acc_dup | (|(acc_mask & onehot));
        next_cnt  = (acc_cnt == CNT_MAX) ? acc_cnt : acc_cnt + 1'b1;
    end

    // Frame collection and result hold; reset discards any partial frame
    // and drops a held result without a handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= COLLECT;
            acc_mask  <= '0;
            acc_cnt   <= '0;
            acc_dup   <= 1'b0;
            out_mask  <= '0;
            out_count <= '0;
            out_dup   <= 1'b0;
        end else begin
            case (state)
                COLLECT: begin
                    if (accept) begin
                        if (in_last) begin
                            out_mask  <= next_mask;
                            out_count <= next_cnt;
                            out_dup   <= next_dup;
                            acc_mask  <= '0;
                            acc_cnt   <= '0;
                            acc_dup   <= 1'b0;
                            state     <= HOLD;
                        end else begin
                            acc_mask  <= next_mask;
                            acc_cnt   <= next_cnt;
                            acc_dup   <= next_dup;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state <= COLLECT;
                    end
                end
                default: begin
                    state <= COLLECT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_index_decoder.sv
// Directed bench for index_decoder: framed index streams with hand-computed
// masks, counts and duplicate flags, including saturation, back-pressure,
// back-to-back frames and asynchronous reset mid-frame and mid-hold.

module tb_index_decoder;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] in_idx;
    logic       in_last;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_mask;
    logic [2:0] out_count;
    logic       out_dup;

    int compared;
    int mismatched;

    index_decoder #(.IDX_W(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_idx    (in_idx),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_mask  (out_mask),
        .out_count (out_count),
        .out_dup   (out_dup)
    );

    // Free-running 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic v, input logic [1:0] idx,
                                 input logic last, input logic ordy);
        in_valid  = v;
        in_idx    = idx;
        in_last   = last;
        out_ready = ordy;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic compare(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag, input logic rdy,
                               input logic vld, input logic [3:0] mask,
                               input logic [2:0] cnt, input logic dup);
        compare({tag, ".in_ready"},  {31'b0, in_ready},  {31'b0, rdy});
        compare({tag, ".out_valid"}, {31'b0, out_valid}, {31'b0, vld});
        compare({tag, ".out_mask"},  {28'b0, out_mask},  {28'b0, mask});
        compare({tag, ".out_count"}, {29'b0, out_count}, {29'b0, cnt});
        compare({tag, ".out_dup"},   {31'b0, out_dup},   {31'b0, dup});
    endtask

    // Linear sequence of directed steps; every check lands 1 unit after a
    // rising edge or between edges.
    initial begin
        logic [1:0] seq9 [9];
        compared   = 0;
        mismatched = 0;
        seq9 = '{2'd1, 2'd1, 2'd2, 2'd1, 2'd0, 2'd3, 2'd3, 2'd2, 2'd1};

        rst = 1'b1;
        applyStimulus(1'b0, 2'd0, 1'b0, 1'b0);
        #3;
        checkOutput("reset", 1'b1, 1'b0, 4'b0000, 3'd0, 1'b0);
        tick();
        rst = 1'b0;

        // Frame 0,1,3 with out_ready high: one-cycle result.
        applyStimulus(1'b1, 2'd0, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b1, 2'd1, 1'b0, 1'b1);
        tick();
        checkOutput("f1_mid", 1'b1, 1'b0, 4'b0000, 3'd0, 1'b0);
        applyStimulus(1'b1, 2'd3, 1'b1, 1'b1);
        tick();
        checkOutput("f1_hold", 1'b0, 1'b1, 4'b1011, 3'd3, 1'b0);
        applyStimulus(1'b0, 2'd0, 1'b0, 1'b1);
        tick();
        checkOutput("f1_done", 1'b1, 1'b0, 4'b1011, 3'd3, 1'b0);

        // Single beat idx 2 under back-pressure; in_valid pulses ignored.
        applyStimulus(1'b1, 2'd2, 1'b1, 1'b0);
        tick();
        checkOutput("f2_hold0", 1'b0, 1'b1, 4'b0100, 3'd1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(i[0] ? 1'b0 : 1'b1, 2'd0, 1'b1, 1'b0);
            tick();
            checkOutput("f2_hold", 1'b0, 1'b1, 4'b0100, 3'd1, 1'b0);
        end
        applyStimulus(1'b0, 2'd0, 1'b0, 1'b1);
        tick();
        checkOutput("f2_done", 1'b1, 1'b0, 4'b0100, 3'd1, 1'b0);

        // Nine beats: saturating count and duplicate flag.
        for (int i = 0; i < 9; i++) begin
            applyStimulus(1'b1, seq9[i], (i == 8) ? 1'b1 : 1'b0, 1'b0);
            tick();
        end
        checkOutput("f3_hold", 1'b0, 1'b1, 4'b1111, 3'd7, 1'b1);
        applyStimulus(1'b0, 2'd0, 1'b0, 1'b1);
        tick();
        checkOutput("f3_done", 1'b1, 1'b0, 4'b1111, 3'd7, 1'b1);

        // Back-to-back frames {0} then {3}, second beat offered continuously.
        applyStimulus(1'b1, 2'd0, 1'b1, 1'b1);
        tick();
        checkOutput("f4a_hold", 1'b0, 1'b1, 4'b0001, 3'd1, 1'b0);
        applyStimulus(1'b1, 2'd3, 1'b1, 1'b1);
        tick();
        checkOutput("f4_turn", 1'b1, 1'b0, 4'b0001, 3'd1, 1'b0);
        tick();
        checkOutput("f4b_hold", 1'b0, 1'b1, 4'b1000, 3'd1, 1'b0);
        applyStimulus(1'b0, 2'd0, 1'b0, 1'b1);
        tick();

        // Reset after two beats of a frame; no residue afterwards.
        applyStimulus(1'b1, 2'd2, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 2'd3, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 2'd0, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        checkOutput("f5_rst", 1'b1, 1'b0, 4'b0000, 3'd0, 1'b0);
        #1;
        rst = 1'b0;
        applyStimulus(1'b1, 2'd0, 1'b1, 1'b0);
        tick();
        checkOutput("f5_hold", 1'b0, 1'b1, 4'b0001, 3'd1, 1'b0);

        // Asynchronous reset while a result is held.
        applyStimulus(1'b0, 2'd0, 1'b0, 1'b0);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("f6_rst", 1'b1, 1'b0, 4'b0000, 3'd0, 1'b0);
        rst = 1'b0;
        tick();
        checkOutput("f6_idle", 1'b1, 1'b0, 4'b0000, 3'd0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/index_decoder.md
# index_decoder

Sequential decoder that rebuilds request masks from streams of binary indices. It is the inverse of the team's priority encoder: that block collapses a 4-bit request vector to a 2-bit index, and this block accepts a framed stream of indices over a valid/ready handshake. It ORs the one-hot decode of each index into a mask and, at end of frame, presents the mask, a beat count and a duplicate flag on a held output handshake. It sits on the consumer side of any link that transports encoded grants or requests as index beats.

## Interface
- IDX_W, default 2: index width; mask width is 2**IDX_W (4 by default).
- clk  input  1  rising-edge clock, single clock domain.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  an index beat is offered.
- in_ready  output  1  the block can accept a beat. It is a function of the state register only.
- in_idx  input  IDX_W  the index to decode.
- in_last  input  1  marks the final beat of a frame. Qualified by in_valid.
- out_valid  output  1  a frame result is held on out_*.
- out_ready  input  1  the downstream consumer takes the result.
- out_mask  output  2**IDX_W  OR of the one-hot decodes of every beat in the frame.
- out_count  output  IDX_W+1  number of beats in the frame, saturating.
- out_dup  output  1  at least one index repeated within the frame.

## Operation
- Beat accept is defined as in_valid & in_ready.
- There are two states, COLLECT and HOLD.
- COLLECT:
  - in_ready=1 and out_valid=0.
  - On each accept: acc_mask |= (1 << in_idx).
  - If acc_mask[in_idx] was already 1 before the update, acc_dup <= 1 (sticky within the frame).
  - acc_cnt increments and saturates at 2**(IDX_W+1)-1 (7 by default). It does not wrap.
- Accept with in_last=1:
  - Load out_mask, out_count and out_dup with the post-update accumulator values. This includes the current beat.
  - Clear the accumulators.
  - Move to HOLD.
- HOLD:
  - in_ready=0 and out_valid=1.
  - out_* are stable until the handshake completes.
  - in_valid is ignored and no beat is consumed.
  - When out_valid & out_ready, return to COLLECT on the next edge.
  - out_valid drops in that same edge. out_mask, out_count and out_dup keep their last values; only out_valid qualifies them.
- A single-beat frame (in_last on the first beat) is legal: count=1, dup=0, mask=one-hot(idx).
- in_idx is always in range by construction, since every IDX_W-bit value maps to one mask bit.
- There is no empty-frame form. A frame always contains at least one beat.

## Timing
- Reset state: COLLECT, in_ready=1, out_valid=0, out_mask=0, out_count=0, out_dup=0, all accumulators=0.
- Reset asserted mid-frame or during HOLD:
  - Takes effect immediately and asynchronously.
  - The partial frame is discarded and a held result is dropped without a handshake.
- Latency:
  - out_valid rises on the clock edge that accepts the last beat, so it is visible 1 cycle after the in_last beat is presented.
  - in_ready is 0 starting the cycle after that edge.
- Back-pressure:
  - out_ready may be held low indefinitely; the result and in_ready=0 persist.
  - out_ready asserted while out_valid=0 has no effect.
- Handshake turnaround: after the out handshake edge, in_ready=1 in the very next cycle.
  - Minimum frame period is N beats + 1 HOLD cycle.
  - There is no bypass from the out handshake to in_ready in the same cycle.
- in_ready and out_valid are both driven from the state register only, with no combinational path from inputs.

## Test plan
- Reset then frame idx 0,1,3 (last on 3), out_ready=1 → out_valid for exactly 1 cycle, out_mask=4'b1011, out_count=3, out_dup=0; in_ready=0 for that cycle.
- Single beat idx=2 with in_last, out_ready=0 for 5 cycles then 1 → out_mask=4'b0100, count=1, held stable 6 cycles; in_valid pulses during HOLD are not consumed and in_ready=0 throughout.
- Frame 1,1,2,1,0,3,3,2,1 (9 beats, last on final) → out_mask=4'b1111, out_count=7 (saturated), out_dup=1.
- Back-to-back frames {0} then {3}: second frame's beat is offered continuously → accepted the cycle after the first out handshake; second result out_mask=4'b1000, out_dup=0 (the accumulator is cleared between frames).
- Assert rst after 2 beats (idx 2,3) of a frame, release, then send idx 0 with last → out_mask=4'b0001, count=1; no leftover bits from the aborted frame.
- Assert rst while out_valid=1 → out_valid, out_mask, out_count and out_dup go to 0 immediately, without waiting for a clock edge; in_ready=1.
